// File: rtl/synth_pkg.sv
// Shared synthesizer types and constants: envelope state encoding and the
// Q12.20 fixed-point format used by the volume path.
package synth_pkg;

  localparam int FRAC_BITS = 20;

  // 1.0 in Q12.20
  localparam logic [31:0] ENV_PEAK = 32'h0010_0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// With TICK_DIV = 1 the tick is high on every cycle.
module tick_prescaler #(
  parameter int TICK_DIV = 24000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/envelope_generator.sv
// Per-voice ADSR envelope producing an unsigned Q12.20 volume word.
// Level updates happen on prescaled ticks; gate events act on every clock.
module envelope_generator
  import synth_pkg::*;
#(
  parameter int TICK_DIV  = 24000,
  parameter int FRAC_BITS = synth_pkg::FRAC_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gate,
  input  logic [31:0] attack_step,
  input  logic [31:0] decay_step,
  input  logic [31:0] sustain_level,
  input  logic [31:0] release_step,
  output logic [31:0] level,
  output env_state_t  state,
  output logic        active
);

  localparam logic [32:0] PEAK     = 33'd1 << FRAC_BITS;
  localparam logic [31:0] PEAK_LVL = PEAK[31:0];

  logic        tick;
  env_state_t  state_q, state_d;
  logic [31:0] level_q, level_d;
  logic [31:0] sustain_eff;
  logic [32:0] attack_sum;
  logic [32:0] decay_diff;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Arithmetic is one bit wider than the level so overshoot and borrow are
  // visible and the result can be clamped instead of wrapping.
  always_comb begin
    sustain_eff = (sustain_level > PEAK_LVL) ? PEAK_LVL : sustain_level;
    attack_sum  = {1'b0, level_q} + {1'b0, attack_step};
    decay_diff  = {1'b0, level_q} - {1'b0, decay_step};
  end

  // NOTE: defaults first so every path assigns state_d/level_d and no latch
  // is inferred.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      IDLE: begin
        level_d = '0;
        if (gate) state_d = ATTACK;
      end
      ATTACK: begin
        if (!gate) begin
          state_d = RELEASE;
        end else if (tick) begin
          if (attack_step == '0 || attack_sum >= PEAK) begin
            level_d = PEAK_LVL;
            state_d = DECAY;
          end else begin
            level_d = attack_sum[31:0];
          end
        end
      end
      DECAY: begin
        if (!gate) begin
          state_d = RELEASE;
        end else if (tick) begin
          if (decay_step == '0 || decay_diff[32] || decay_diff[31:0] <= sustain_eff) begin
            level_d = sustain_eff;
            state_d = SUSTAIN;
          end else begin
            level_d = decay_diff[31:0];
          end
        end
      end
      SUSTAIN: begin
        if (!gate) begin
          state_d = RELEASE;
        end else if (tick) begin
          level_d = sustain_eff;
        end
      end
      RELEASE: begin
        // Legato retrigger: attack resumes from the current level.
        if (gate) begin
          state_d = ATTACK;
        end else if (tick) begin
          if (release_step == '0 || level_q <= release_step) begin
            level_d = '0;
            state_d = IDLE;
          end else begin
            level_d = level_q - release_step;
          end
        end
      end
      default: begin
        state_d = IDLE;
        level_d = '0;
      end
    endcase
  end

  always_comb begin
    active = (state_q != IDLE);
    state  = state_q;
    level  = level_q;
  end

endmodule

// File: tb/tb_envelope_generator.sv
// Scoreboard bench for envelope_generator with TICK_DIV = 4: the stimulus pushes
// the expected (state, level) sequence and a monitor checks each output change.
module tb_envelope_generator;
  import synth_pkg::*;

  localparam int TICK_DIV = 4;

  typedef struct packed {
    logic [2:0]  st;
    logic [31:0] lvl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gate;
  logic [31:0] attack_step, decay_step, sustain_level, release_step;
  logic [31:0] level;
  env_state_t  state;
  logic        active;

  int total = 0;
  int bad   = 0;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [2:0]  prev_st  = 3'd0;
  logic [31:0] prev_lvl = 32'd0;
  logic [1:0]  phase;

  envelope_generator #(
    .TICK_DIV  (TICK_DIV),
    .FRAC_BITS (20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .level         (level),
    .state         (state),
    .active        (active)
  );

  always #5 clk = ~clk;

  // Reference tick phase: phase == 3 marks a tick cycle, so phase == 0 right
  // after the edge that applied a tick.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= 2'd0;
    else        phase <= (phase == 2'd3) ? 2'd0 : phase + 2'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [31:0] lvl);
    exp_t e;
    e.st  = st;
    e.lvl = lvl;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_steps(input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] s, input logic [31:0] r);
    attack_step   = a;
    decay_step    = d;
    sustain_level = s;
    release_step  = r;
  endtask

  task automatic wait_state(input env_state_t s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      cycles(1);
      n++;
    end
    check("wait_state", state, s);
  endtask

  task automatic wait_level(input logic [31:0] lv, input int budget);
    int n = 0;
    while (level !== lv && n < budget) begin
      cycles(1);
      n++;
    end
    check("wait_level", level, lv);
  endtask

  // Monitor: every change of (state, level) is one output event.
  always @(negedge clk) begin
    if (state !== prev_st || level !== prev_lvl) begin
      if (level !== prev_lvl) check("level_on_tick", {30'd0, phase}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: state=%0d level=%h at %0t", state, level, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("state_seq", state, mon_e.st);
        check("level_seq", level, mon_e.lvl);
      end
      prev_st  = state;
      prev_lvl = level;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    gate  = 1'b0;
    set_steps(32'h0, 32'h0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;

    // Reset with gate held high, then full ADSR
    gate = 1'b1;
    set_steps(32'h0004_0000, 32'h0002_0000, 32'h0008_0000, 32'h0001_0000);
    cycles(3);
    check("reset_level", level, 32'h0);
    check("reset_state", state, IDLE);
    check("reset_active", active, 1'b0);
    push(ATTACK, 32'h0);
    push(ATTACK, 32'h0004_0000);
    push(ATTACK, 32'h0008_0000);
    push(ATTACK, 32'h000C_0000);
    push(DECAY,  ENV_PEAK);
    push(DECAY,  32'h000E_0000);
    push(DECAY,  32'h000C_0000);
    push(DECAY,  32'h000A_0000);
    push(SUSTAIN, 32'h0008_0000);
    rst_n = 1'b1;
    cycles(1);
    check("gate_to_attack", state, ATTACK);
    check("active_high", active, 1'b1);
    wait_state(SUSTAIN, 40);
    cycles(8);
    push(RELEASE, 32'h0008_0000);
    for (int i = 7; i >= 1; i--) push(RELEASE, 32'(i) << 16);
    push(IDLE, 32'h0);
    gate = 1'b0;
    cycles(1);
    check("gate_to_release", state, RELEASE);
    check("release_hold", level, 32'h0008_0000);
    wait_state(IDLE, 40);
    check("idle_active", active, 1'b0);

    // Attack clamp and sustain above PEAK; zero release drops in one tick
    set_steps(32'h0006_0000, 32'h0002_0000, 32'h0020_0000, 32'h0);
    push(ATTACK, 32'h0);
    push(ATTACK, 32'h0006_0000);
    push(ATTACK, 32'h000C_0000);
    push(DECAY,  ENV_PEAK);
    push(SUSTAIN, ENV_PEAK);
    gate = 1'b1;
    wait_state(SUSTAIN, 30);
    cycles(8);
    check("sustain_clamp", level, ENV_PEAK);
    push(RELEASE, ENV_PEAK);
    push(IDLE, 32'h0);
    gate = 1'b0;
    wait_state(IDLE, 20);

    // All steps zero
    set_steps(32'h0, 32'h0, 32'h0008_0000, 32'h0);
    push(ATTACK, 32'h0);
    push(DECAY,  ENV_PEAK);
    push(SUSTAIN, 32'h0008_0000);
    gate = 1'b1;
    wait_state(SUSTAIN, 20);
    cycles(8);
    push(RELEASE, 32'h0008_0000);
    push(IDLE, 32'h0);
    gate = 1'b0;
    wait_state(IDLE, 20);

    // Legato retrigger from 0x6_0000
    set_steps(32'h0004_0000, 32'h0002_0000, 32'h0008_0000, 32'h0001_0000);
    push(ATTACK, 32'h0);
    push(ATTACK, 32'h0004_0000);
    push(ATTACK, 32'h0008_0000);
    push(ATTACK, 32'h000C_0000);
    push(DECAY,  ENV_PEAK);
    push(DECAY,  32'h000E_0000);
    push(DECAY,  32'h000C_0000);
    push(DECAY,  32'h000A_0000);
    push(SUSTAIN, 32'h0008_0000);
    gate = 1'b1;
    wait_state(SUSTAIN, 40);
    push(RELEASE, 32'h0008_0000);
    push(RELEASE, 32'h0007_0000);
    push(RELEASE, 32'h0006_0000);
    gate = 1'b0;
    wait_level(32'h0006_0000, 20);
    push(ATTACK, 32'h0006_0000);
    push(ATTACK, 32'h000A_0000);
    push(ATTACK, 32'h000E_0000);
    push(DECAY,  ENV_PEAK);
    push(DECAY,  32'h000E_0000);
    push(DECAY,  32'h000C_0000);
    push(DECAY,  32'h000A_0000);
    push(SUSTAIN, 32'h0008_0000);
    gate = 1'b1;
    cycles(1);
    check("retrigger_state", state, ATTACK);
    check("retrigger_level", level, 32'h0006_0000);
    wait_state(SUSTAIN, 40);
    release_step = 32'h0;
    push(RELEASE, 32'h0008_0000);
    push(IDLE, 32'h0);
    gate = 1'b0;
    wait_state(IDLE, 20);

    // Gate falls on the tick cycle during ATTACK
    release_step = 32'h0001_0000;
    push(ATTACK, 32'h0);
    push(ATTACK, 32'h0004_0000);
    gate = 1'b1;
    wait_level(32'h0004_0000, 20);
    n = 0;
    while (phase != 2'd3 && n < 8) begin
      cycles(1);
      n++;
    end
    check("align_tick", {30'd0, phase}, 32'd3);
    push(RELEASE, 32'h0004_0000);
    push(RELEASE, 32'h0003_0000);
    push(RELEASE, 32'h0002_0000);
    push(RELEASE, 32'h0001_0000);
    push(IDLE, 32'h0);
    gate = 1'b0;
    cycles(1);
    check("collision_state", state, RELEASE);
    check("collision_level", level, 32'h0004_0000);
    wait_state(IDLE, 30);

    // Asynchronous reset mid-ramp
    push(ATTACK, 32'h0);
    push(ATTACK, 32'h0004_0000);
    gate = 1'b1;
    wait_level(32'h0004_0000, 20);
    cycles(1);
    push(IDLE, 32'h0);
    rst_n = 1'b0;
    #1;
    check("async_rst_level", level, 32'h0);
    check("async_rst_state", state, IDLE);
    check("async_rst_active", active, 1'b0);
    gate = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(10);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycles(1);
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
